// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path and the character-grid writer.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int         DATA_BITS = 8;
    localparam logic [7:0] ASCII_LF  = 8'h0A;

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
// A synchronous clear restarts the count so the tick phase follows the caller.
module baud_tick_gen #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: wrap at DIV-1, or restart when cleared.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A clear cycle never produces a tick, so the first tick after a clear is DIV clocks later.
    assign tick = (cnt_q == LAST) && !clr;

endmodule

// File: rtl/uart_rx_char.sv
// 8N1 UART receiver: oversampled start-edge detection, mid-bit sampling,
// one-cycle strobes for a good byte (en) or a low stop bit (frame_err).
module uart_rx_char
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       en,
    output logic       frame_err,
    output logic       busy
);

    localparam int TICK_DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int SAMPLE_W = $clog2(OVERSAMPLE);

    localparam logic [SAMPLE_W-1:0] HALF_LAST = SAMPLE_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMPLE_W-1:0] FULL_LAST = SAMPLE_W'(OVERSAMPLE - 1);
    localparam logic [2:0]          LAST_IDX  = 3'(DATA_BITS - 1);

    // Realised bit period versus the ideal one must agree to within 2%.
    localparam longint REAL_PERIOD_X_BAUD = longint'(TICK_DIV) * OVERSAMPLE * BAUD;
    localparam longint PERIOD_DIFF        = (REAL_PERIOD_X_BAUD > longint'(CLK_HZ))
                                          ? REAL_PERIOD_X_BAUD - longint'(CLK_HZ)
                                          : longint'(CLK_HZ) - REAL_PERIOD_X_BAUD;
    localparam bit     BAUD_RATE_OK       = (TICK_DIV >= 1) && (PERIOD_DIFF * 50 <= longint'(CLK_HZ));
    localparam bit     OVERSAMPLE_OK      = (OVERSAMPLE >= 8) && (OVERSAMPLE % 2 == 0);

    logic [1:0]          sync_q;
    logic                rx_s;
    logic                rx_prev_q;
    uart_state_t         state_q, state_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic [2:0]          idx_q, idx_d;
    logic [7:0]          shift_q, shift_d;
    logic [7:0]          data_q, data_d;
    logic                en_q, en_d;
    logic                ferr_q, ferr_d;
    logic                busy_q;
    logic                tick;
    logic                tick_clr;

    baud_tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (tick_clr),
        .tick  (tick)
    );

    assign rx_s = sync_q[1];

    // Two-flop synchronizer plus one delayed copy for falling-edge detection; idle line is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], rx};
            rx_prev_q <= rx_s;
        end
    end

    // Receive FSM next-state, datapath and strobe logic.
    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        data_d   = data_q;
        en_d     = 1'b0;
        ferr_d   = 1'b0;
        tick_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Needs a real high-to-low transition, so a held-low line cannot retrigger.
                if (rx_prev_q && !rx_s) begin
                    state_d  = START;
                    sample_d = '0;
                    tick_clr = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (sample_q == HALF_LAST) begin
                        if (!rx_s) begin
                            state_d  = DATA;
                            sample_d = '0;
                            idx_d    = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        sample_d = sample_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (sample_q == FULL_LAST) begin
                        sample_d       = '0;
                        shift_d[idx_q] = rx_s;
                        idx_d          = idx_q + 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_d = STOP;
                        end
                    end else begin
                        sample_d = sample_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (sample_q == FULL_LAST) begin
                        if (rx_s) begin
                            data_d = shift_q;
                            en_d   = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                        state_d = IDLE;
                    end else begin
                        sample_d = sample_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; busy tracks the next state so it drops with the en strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sample_q <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            en_q     <= 1'b0;
            ferr_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            en_q     <= en_d;
            ferr_q   <= ferr_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    // Simulation-time sanity check of the derived divider and oversample ratio.
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (BAUD_RATE_OK && OVERSAMPLE_OK)
                else $error("uart_rx_char: divider gives more than 2%% baud error or bad OVERSAMPLE");
        end
    end

    assign data      = data_q;
    assign en        = en_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;

endmodule
